spike_rate_window_counter: RTL and testbench
============================================

// Module: spike_rate_window_counter
// PURPOSE
//  Downstream consumer of the recurrent LIF neuron's spike_out. Counts rising edges of the
//  spike train over a programmable window of enabled cycles. At each window close, pushes the
//  count into a small FWFT FIFO, read through a valid/ready port by the chip I/O / readout logic.
//  Turns the neuron's 1-bit spike stream into 8-bit rate samples for off-chip observation.
// PARAMETERS
//  CNT_W       8   width of spike count / rate_data (saturating)
//  FIFO_DEPTH  4   rate sample FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1       system clock (same clock as neuron)
//  reset_n      in   1       asynchronous reset, active-low
//  enable       in   1       neuron update strobe; window timer advances only when high
//  clear        in   1       synchronous clear: FIFO, counters, overflow, FSM -> IDLE
//  spike_in     in   1       spike_out of the recurrent neuron
//  window_len   in   8       window length in enabled cycles; 0 means 256
//  rate_data    out  CNT_W   head-of-FIFO spike count (valid only when rate_valid)
//  rate_valid   out  1       FIFO non-empty
//  rate_ready   in   1       consumer accepts head when rate_valid & rate_ready
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  entries held
//  overflow     out  1       sticky: a window sample was dropped because FIFO was full
// BEHAVIOUR
//  - Reset (async) / clear (sync, priority over all else): every output 0, FIFO empty,
//    spike_d=0, win_cnt=0, spike_cnt=0, FSM=IDLE.
//  - Edge detect: edge = spike_in & ~spike_d, spike_d registered every clk (independent of enable).
//    Level held high for N cycles counts once.
//  - FSM IDLE: latch win_len_q = window_len (0 -> 256); edges ignored; next cycle -> COUNT.
//  - FSM COUNT: edges counted every clk, saturating at 2^CNT_W-1. win_cnt increments on
//    enable cycles only; enable=0 freezes timer, not edge counting.
//  - Window close = enable & (win_cnt == win_len_q-1): sample = spike_cnt + edge (edge in the
//    closing cycle belongs to the closing window, saturating); push sample; spike_cnt<=0;
//    win_cnt<=0; re-latch win_len_q from window_len (mid-window changes take effect next window).
//  - Latency: sample pushed at close cycle edge; rate_valid high the following cycle if FIFO was empty.
//  - FIFO is first-word-fall-through; pop on rate_valid & rate_ready. rate_data stable while
//    rate_valid & ~rate_ready.
//  - Push when full: if simultaneous pop, push accepted (level unchanged); else sample dropped,
//    overflow<=1 (held until clear/reset). Pop when empty: ignored.
//  - fifo_level tracks pushes/pops exactly; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  SPIKE_ISI_EN defined: block also tracks minimum inter-spike interval per window: clk cycles
//   between consecutive edges (all clocks, saturating 255), 255 if <2 edges in window.
//   Stored with the count in each FIFO entry; extra port isi_min out 8 = head entry's ISI
//   (0 at reset). Tracker resets at window close along with spike_cnt.
//  SPIKE_ISI_EN undefined: no isi_min port, FIFO entries CNT_W wide, no ISI logic.
// TESTING
//  1 window_len=10, enable=1, 1-cycle spikes at window cycles 1,4,7 -> rate_data=3, rate_valid
//    1 cycle after close; (ISI_EN) isi_min=3.
//  2 spike_in held high 5 cycles inside one window -> count 1; spike on closing cycle -> in that window.
//  3 rate_ready=0, 5 windows close -> fifo_level=4, overflow=1; drain -> first 4 samples in order.
//  4 full FIFO, rate_ready=1 on the close cycle -> push accepted, level stays 4, overflow=0.
//  5 enable=0, 300 spike toggles, then enable=1 to close -> rate_data=255 (saturated).
//  6 clear or reset_n=0 mid-window with FIFO non-empty -> level 0, valid 0, overflow 0;
//    next window runs full window_len; window_len=0 -> window closes after 256 enabled cycles.

Source files
------------

// File: rtl/spike_rate_window_counter.sv
// spike_rate_window_counter: counts spike rising edges per programmable window into an FWFT FIFO
// Optional feature macro: SPIKE_ISI_EN adds per-window minimum inter-spike interval (isi_min).
// Ports:
//   clk, reset_n (async, active-low), enable (window timer strobe), clear (sync clear)
//   spike_in (neuron spike), window_len (enabled cycles per window, 0 = 256)
//   rate_data/rate_valid/rate_ready (FIFO head, valid/ready), fifo_level, overflow (sticky drop)
//   isi_min (SPIKE_ISI_EN only: head entry's minimum ISI)
module spike_rate_window_counter #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          spike_in,
  input  logic [7:0]                    window_len,
  output logic [CNT_W-1:0]              rate_data,
  output logic                          rate_valid,
  input  logic                          rate_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef SPIKE_ISI_EN
  ,
  output logic [7:0]                    isi_min
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SPIKE_ISI_EN
  localparam int EW = CNT_W + 8;
`else
  localparam int EW = CNT_W;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic             spike_dly_q, spike_dly_d;
  logic [8:0]       win_len_q, win_len_d, win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic             counting, ev, win_close, restart, pop, push, full;
  logic [8:0]       len_sel;
  logic [CNT_W-1:0] sample;
  logic [EW-1:0]    entry;
`ifdef SPIKE_ISI_EN
  logic [7:0]       isi_cnt_q, isi_cnt_d, isi_min_q, isi_min_d, isi_cand, isi_sample;
  logic             seen_q, seen_d;
`endif
  always_comb begin
    counting    = state_q == S_COUNT;
    // edges in IDLE are ignored; spike_dly still tracks every clock
    ev          = spike_in & ~spike_dly_q & counting;
    win_close   = counting & enable & (win_cnt_q == win_len_q - 9'd1);
    restart     = clear | win_close | ~counting;
    len_sel     = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
    // the edge seen on the closing cycle belongs to the closing window
    sample      = (spike_cnt_q == CNT_MAX) ? CNT_MAX : spike_cnt_q + CNT_W'(ev);
    rate_valid  = level_q != '0;
    pop         = rate_valid & rate_ready;
    full        = level_q == (AW+1)'(FIFO_DEPTH);
    push        = win_close & (~full | pop);
    spike_dly_d = clear ? 1'b0 : spike_in;
    state_d     = clear ? S_IDLE : S_COUNT;
    win_len_d   = clear ? 9'd0 : (~counting | win_close) ? len_sel : win_len_q;
    win_cnt_d   = restart ? 9'd0 : enable ? win_cnt_q + 9'd1 : win_cnt_q;
    spike_cnt_d = restart ? '0 : (ev && spike_cnt_q != CNT_MAX) ? spike_cnt_q + 1'b1 : spike_cnt_q;
    wr_ptr_d    = clear ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d    = clear ? '0 : rd_ptr_q + AW'(pop);
    level_d     = clear ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d       = clear ? 1'b0 : ovf_q | (win_close & full & ~pop);
`ifdef SPIKE_ISI_EN
    // isi_cnt_q holds clocks elapsed since the previous edge
    isi_cand    = (ev & seen_q) ? isi_cnt_q : 8'hFF;
    isi_sample  = (isi_cand < isi_min_q) ? isi_cand : isi_min_q;
    isi_cnt_d   = clear ? 8'd0 : ev ? 8'd1 : (isi_cnt_q == 8'hFF) ? 8'hFF : isi_cnt_q + 8'd1;
    isi_min_d   = restart ? 8'hFF : isi_sample;
    seen_d      = restart ? 1'b0 : seen_q | ev;
    entry       = {isi_sample, sample};
    isi_min     = rate_valid ? mem_q[rd_ptr_q][EW-1:CNT_W] : 8'd0;
`else
    entry       = sample;
`endif
    rate_data   = rate_valid ? mem_q[rd_ptr_q][CNT_W-1:0] : '0;
    fifo_level  = level_q;
    overflow    = ovf_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      spike_dly_q <= 1'b0;
      win_len_q   <= 9'd0;
      win_cnt_q   <= 9'd0;
      spike_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
`ifdef SPIKE_ISI_EN
      isi_cnt_q   <= 8'd0;
      isi_min_q   <= 8'hFF;
      seen_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      spike_dly_q <= spike_dly_d;
      win_len_q   <= win_len_d;
      win_cnt_q   <= win_cnt_d;
      spike_cnt_q <= spike_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
`ifdef SPIKE_ISI_EN
      isi_cnt_q   <= isi_cnt_d;
      isi_min_q   <= isi_min_d;
      seen_q      <= seen_d;
`endif
    end
  end
  // storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end
endmodule

// File: tb/tb_spike_rate_window_counter.sv
// tb_spike_rate_window_counter: directed self-checking bench for spike_rate_window_counter
module tb_spike_rate_window_counter;
  logic       clk = 1'b0;
  logic       reset_n, enable, clear, spike_in, rate_ready;
  logic [7:0] window_len;
  logic [7:0] rate_data;
  logic       rate_valid, overflow;
  logic [2:0] fifo_level;
`ifdef SPIKE_ISI_EN
  logic [7:0] isi_min;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [255:0] pat;
  spike_rate_window_counter #(.CNT_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .spike_in(spike_in),
    .window_len(window_len), .rate_data(rate_data), .rate_valid(rate_valid),
    .rate_ready(rate_ready), .fifo_level(fifo_level), .overflow(overflow)
`ifdef SPIKE_ISI_EN
    , .isi_min(isi_min)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic chk_isi(input string tag, input logic [7:0] exp);
`ifdef SPIKE_ISI_EN
    chk(tag, {24'd0, isi_min}, {24'd0, exp});
`endif
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_window(input int n, input logic [255:0] p);
    for (int k = 0; k < n; k++) begin
      spike_in = p[k];
      step();
    end
  endtask
  task automatic pop_check(input string tag, input logic [7:0] exp, input logic [7:0] exp_isi);
    chk({tag, "_valid"}, {31'd0, rate_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rate_data}, {24'd0, exp});
    chk_isi({tag, "_isi"}, exp_isi);
    enable = 1'b0;
    rate_ready = 1'b1;
    spike_in = 1'b0;
    step();
    rate_ready = 1'b0;
    enable = 1'b1;
  endtask
  initial begin
    reset_n = 1'b1; enable = 1'b0; clear = 1'b0; spike_in = 1'b0;
    rate_ready = 1'b0; window_len = 8'd10;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rate_valid}, 32'd0);
    chk("rst_data", {24'd0, rate_data}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk_isi("rst_isi", 8'd0);
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    // 1: spikes at window cycles 1,4,7 -> 3, valid one cycle after close
    pat = '0; pat[1] = 1'b1; pat[4] = 1'b1; pat[7] = 1'b1;
    run_window(9, pat);
    chk("t1_pre_valid", {31'd0, rate_valid}, 32'd0);
    run_window(1, pat >> 9);
    chk("t1_level", {29'd0, fifo_level}, 32'd1);
    pop_check("t1", 8'd3, 8'd3);
    chk("t1_empty", {29'd0, fifo_level}, 32'd0);
    // 2: level held 5 cycles counts once, closing-cycle spike joins this window
    pat = '0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b1; pat[9] = 1'b1;
    run_window(10, pat);
    pop_check("t2", 8'd2, 8'd7);
    // 3: five windows with no reader -> four kept in order, fifth dropped
    for (int c = 1; c <= 5; c++) begin
      pat = '0;
      for (int j = 0; j < c; j++) pat[2*j] = 1'b1;
      run_window(10, pat);
      if (c == 4) begin
        chk("t3_level4", {29'd0, fifo_level}, 32'd4);
        chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
      end
    end
    chk("t3_level", {29'd0, fifo_level}, 32'd4);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    pop_check("t3_s1", 8'd1, 8'd255);
    pop_check("t3_s2", 8'd2, 8'd2);
    pop_check("t3_s3", 8'd3, 8'd2);
    pop_check("t3_s4", 8'd4, 8'd2);
    chk("t3_drained", {29'd0, fifo_level}, 32'd0);
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    // 6a: synchronous clear mid-window with FIFO non-empty
    pat = '0; pat[0] = 1'b1; pat[2] = 1'b1;
    run_window(10, pat);
    pat = '0; pat[1] = 1'b1;
    run_window(5, pat);
    chk("t6_pre_level", {29'd0, fifo_level}, 32'd1);
    clear = 1'b1; spike_in = 1'b0;
    step();
    clear = 1'b0;
    chk("t6_clr_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_clr_valid", {31'd0, rate_valid}, 32'd0);
    chk("t6_clr_ovf", {31'd0, overflow}, 32'd0);
    step();
    pat = '0; pat[3] = 1'b1;
    run_window(9, pat);
    chk("t6_clr_full_len", {31'd0, rate_valid}, 32'd0);
    run_window(1, '0);
    pop_check("t6_clr", 8'd1, 8'd255);
    // 4: full FIFO, reader ready on the close cycle -> push accepted
    for (int c = 1; c <= 4; c++) begin
      pat = '0;
      for (int j = 0; j < c; j++) pat[2*j] = 1'b1;
      run_window(10, pat);
    end
    chk("t4_full", {29'd0, fifo_level}, 32'd4);
    pat = '0; pat[0] = 1'b1; pat[2] = 1'b1; pat[4] = 1'b1; pat[6] = 1'b1; pat[8] = 1'b1;
    run_window(9, pat);
    rate_ready = 1'b1;
    run_window(1, '0);
    rate_ready = 1'b0;
    chk("t4_level", {29'd0, fifo_level}, 32'd4);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);
    pop_check("t4_s2", 8'd2, 8'd2);
    pop_check("t4_s3", 8'd3, 8'd2);
    pop_check("t4_s4", 8'd4, 8'd2);
    pop_check("t4_s5", 8'd5, 8'd2);
    // 5: timer frozen while 300 edges arrive -> saturated count
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      spike_in = 1'b1; step();
      spike_in = 1'b0; step();
    end
    chk("t5_frozen", {31'd0, rate_valid}, 32'd0);
    enable = 1'b1;
    run_window(10, '0);
    pop_check("t5_sat", 8'd255, 8'd2);
    // 6b: async reset mid-window with FIFO non-empty, then 256-cycle window
    pat = '0; pat[0] = 1'b1;
    run_window(10, pat);
    run_window(4, '0);
    window_len = 8'd0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_rst_valid", {31'd0, rate_valid}, 32'd0);
    chk("t6_rst_data", {24'd0, rate_data}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    pat = '0; pat[100] = 1'b1;
    run_window(255, pat);
    chk("t6_len256_pre", {31'd0, rate_valid}, 32'd0);
    run_window(1, '0);
    chk("t6_len256_level", {29'd0, fifo_level}, 32'd1);
    pop_check("t6_len256", 8'd1, 8'd255);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
